alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised, multi-cycle successor to the combinational integer ALU.
- Adds the RV32M/RV64M multiply and divide operations, an XLEN-generic datapath and a valid/ready handshake on both sides.
- Used in the core execute stage and as the scalar arithmetic engine for the FFT control path.
- Basic ops complete in 1 cycle; MUL/DIV use an iterative engine that resolves one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, >= 8.
- SHW, $clog2(XLEN), number of low bits of B used as the shift amount (derived; not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns to IDLE and discards any in-flight op.
- in_valid  input  1  operands and ctrl are valid.
- in_ready  output  1  block can accept an op.
- a  input  XLEN  operand A.
- b  input  XLEN  operand B.
- ctrl  input  5  operation select.
- out_valid  output  1  y is valid.
- out_ready  input  1  consumer accepts y.
- y  output  XLEN  result.
- busy  output  1  state != IDLE.

Behaviour:
- ctrl encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shifts use b[SHW-1:0].
  - 8 SLT (signed), 9 SLTU.
  - 10 MUL (low XLEN bits), 11 MULH (s×s high), 12 MULHSU (signed a × unsigned b, high), 13 MULHU (u×u high).
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18-31: y=0 with 1-cycle latency.
- Reset (rst_n low, any time, including mid-iteration):
  - state=IDLE.
  - y=0, out_valid=0, busy=0, in_ready=1.
  - Iteration counter and partial registers cleared.
- Handshake:
  - Accept occurs on a rising edge where in_valid && in_ready.
  - in_ready = (state==IDLE).
  - No accept is possible while busy or while holding a result.
  - Throughput is at most one op per 2 cycles for basic ops.
  - Inputs are sampled only at accept; later changes are ignored.
- States:
  - IDLE:
    - accept of ctrl 0-9 or 18-31 -> DONE, with y loaded with the combinational result.
    - accept of ctrl 10-13 -> MUL.
    - accept of ctrl 14-17 -> DIV, except special cases, which go straight to DONE.
  - MUL:
    - Radix-2 shift-add on the magnitudes of the operands, over a 2*XLEN product.
    - Counter starts at XLEN and decrements once per cycle.
    - At 0: sign-correct, select the low or high half, then -> DONE.
  - DIV:
    - Restoring divide on magnitudes, one quotient bit per cycle, XLEN cycles.
    - Then apply signs: quotient is negative iff signs differ; remainder takes the sign of the dividend. Then -> DONE.
  - DONE:
    - out_valid=1, y held stable.
    - out_valid && out_ready -> IDLE at that edge.
    - out_valid never drops without out_ready.
- Latency, counted in edges from the accept edge to the first edge where out_valid=1:
  - Basic ops and divide special cases: 1.
  - MUL*/DIV*: XLEN+1.
- Divide special cases (latency 1):
  - b==0: DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): DIV gives a; REM gives 0.
- flush:
  - Highest priority after reset; forces IDLE and out_valid=0 at that edge.
  - Any accept attempted in the same cycle is ignored.
- Arithmetic:
  - All add/sub results wrap modulo 2^XLEN.
  - SRA replicates a[XLEN-1].
  - SLT/SLTU return 1 or 0, zero-extended.
- busy=1 in MUL, DIV and DONE.

Test Plan:
- Basic ops, XLEN=32:
  - ADD 0xFFFFFFFF+1 -> y=0 one edge after accept.
  - SRA 0x80000000 by b=0x24 (amount 4) -> 0xF8000000.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SLTU on the same operands -> 0.
- Multiply:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000 and MUL -> 0x00000000, each with out_valid exactly 33 edges after accept.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF.
  - DIVU 7/0 -> 0xFFFFFFFF and REMU 7/0 -> 7, each at latency 1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000, with REM -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after MUL completes -> out_valid and y remain stable, in_ready=0 throughout; with out_ready=1 -> IDLE on the next edge, in_ready=1.
- Abort:
  - Assert flush at iteration 12 of a DIVU -> IDLE next edge, out_valid never asserts; a following ADD 3+4 -> 7.
  - Repeat with rst_n pulsed low mid-MUL -> all outputs 0 immediately, in_ready=1.
- Parameter sweep XLEN=8:
  - MULHU 0xFF×0xFF -> 0xFE with latency 9.
  - DIV 0x80/0xFF -> 0x80.
  - SLL by b=0x0B (amount 3).
  - ctrl=20 -> y=0.

Source files
------------

// File: rtl/alu_mdu.sv
// Multi-cycle integer ALU with RV-style multiply/divide and valid/ready handshake.
// Basic ops finish in one cycle; MUL*/DIV* iterate one bit per cycle on operand magnitudes.
module alu_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y,
    output logic            busy
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [4:0]        ctrl_q, ctrl_d;
    logic              nega_q, nega_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   y_q, y_d;

    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic              is_mul, is_div, div_signed, div_quo, sa, sb, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res;

    logic [2*XLEN-1:0] mul_sum, mul_fin;
    logic [XLEN-1:0]   mul_y;
    logic [XLEN-1:0]   q_in, q_next, r_next, quo_fin, rem_fin, div_y;
    logic [XLEN:0]     rsh, diff;
    logic              ge;

    assign shamt = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (ctrl)
            5'd0:    alu_res = a + b;
            5'd1:    alu_res = a - b;
            5'd2:    alu_res = a & b;
            5'd3:    alu_res = a | b;
            5'd4:    alu_res = a ^ b;
            5'd5:    alu_res = a << shamt;
            5'd6:    alu_res = a >> shamt;
            5'd7:    alu_res = $unsigned($signed(a) >>> shamt);
            5'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            5'd9:    alu_res = {{(XLEN-1){1'b0}}, a < b};
            default: alu_res = '0;
        endcase
    end

    assign is_mul     = (ctrl >= 5'd10) && (ctrl <= 5'd13);
    assign is_div     = (ctrl >= 5'd14) && (ctrl <= 5'd17);
    assign div_signed = (ctrl == 5'd14) || (ctrl == 5'd16);
    assign div_quo    = (ctrl == 5'd14) || (ctrl == 5'd15);
    // Plain MUL is run unsigned: the low half of the product does not depend on signedness.
    assign sa = ((ctrl == 5'd11) || (ctrl == 5'd12) || div_signed) && a[XLEN-1];
    assign sb = ((ctrl == 5'd11) || div_signed) && b[XLEN-1];
    assign mag_a = sa ? (~a + 1'b1) : a;
    assign mag_b = sb ? (~b + 1'b1) : b;

    assign div_ovf  = div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    assign spec_res = (b == '0) ? (div_quo ? '1 : a) : (div_quo ? a : '0);

    assign mul_sum = acc_q + (opb_q[0] ? mcand_q : '0);
    assign mul_fin = nega_q ? (~mul_sum + 1'b1) : mul_sum;
    assign mul_y   = (ctrl_q == 5'd10) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];

    // Divide: quotient shifts in from the top half, partial remainder lives in the bottom half.
    assign q_in    = acc_q[2*XLEN-1:XLEN];
    assign rsh     = {acc_q[XLEN-1:0], q_in[XLEN-1]};
    assign diff    = rsh - {1'b0, opb_q};
    assign ge      = ~diff[XLEN];
    assign r_next  = ge ? diff[XLEN-1:0] : rsh[XLEN-1:0];
    assign q_next  = {q_in[XLEN-2:0], ge};
    assign quo_fin = nega_q ? (~q_next + 1'b1) : q_next;
    assign rem_fin = negr_q ? (~r_next + 1'b1) : r_next;
    assign div_y   = ((ctrl_q == 5'd14) || (ctrl_q == 5'd15)) ? quo_fin : rem_fin;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        opb_d   = opb_q;
        ctrl_d  = ctrl_q;
        nega_d  = nega_q;
        negr_d  = negr_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    ctrl_d = ctrl;
                    nega_d = sa ^ sb;
                    negr_d = sa;
                    if (is_mul) begin
                        state_d = MUL;
                        cnt_d   = CW'(XLEN);
                        acc_d   = '0;
                        mcand_d = {{XLEN{1'b0}}, mag_a};
                        opb_d   = mag_b;
                    end else if (is_div && ((b == '0) || div_ovf)) begin
                        state_d = DONE;
                        y_d     = spec_res;
                    end else if (is_div) begin
                        state_d = DIV;
                        cnt_d   = CW'(XLEN);
                        acc_d   = {mag_a, {XLEN{1'b0}}};
                        opb_d   = mag_b;
                    end else begin
                        state_d = DONE;
                        y_d     = alu_res;
                    end
                end
            end
            MUL: begin
                acc_d   = mul_sum;
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                // The final step and sign correction share one edge to hit XLEN+1 latency.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    y_d     = mul_y;
                end
            end
            DIV: begin
                acc_d = {q_next, r_next};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    y_d     = div_y;
                end
            end
            default: begin
                if (out_ready) state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            opb_q   <= '0;
            ctrl_q  <= '0;
            nega_q  <= 1'b0;
            negr_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            opb_q   <= opb_d;
            ctrl_q  <= ctrl_d;
            nega_q  <= nega_d;
            negr_q  <= negr_d;
            y_q     <= y_d;
        end
    end

    assign y         = y_q;
    assign out_valid = (state_q == DONE);
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: an XLEN=32 and an XLEN=8 instance on a shared clock/reset.
module tb_alu_mdu;
    typedef struct {
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;

    logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b0, busy32;
    logic [31:0] a32 = '0, b32 = '0, y32;
    logic [4:0]  ctrl32 = '0;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, busy8;
    logic [7:0]  a8 = '0, b8 = '0, y8;
    logic [4:0]  ctrl8 = '0;

    logic [31:0] sb32[$];
    logic [7:0]  sb8[$];
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .ctrl(ctrl32), .out_valid(out_valid32), .out_ready(out_ready32),
        .y(y32), .busy(busy32)
    );

    alu_mdu #(.XLEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .ctrl(ctrl8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .busy(busy8)
    );

    // Drive one op across an accept edge, then scramble the operands to prove they are latched.
    task automatic accept32(input logic [4:0] c, input logic [31:0] x, input logic [31:0] z,
                            input logic [31:0] e);
        @(negedge clk);
        in_valid32 = 1'b1; ctrl32 = c; a32 = x; b32 = z;
        @(posedge clk);
        sb32.push_back(e);
        @(negedge clk);
        in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom; ctrl32 = 5'($urandom);
    endtask

    task automatic accept8(input logic [4:0] c, input logic [7:0] x, input logic [7:0] z,
                           input logic [7:0] e);
        @(negedge clk);
        in_valid8 = 1'b1; ctrl8 = c; a8 = x; b8 = z;
        @(posedge clk);
        sb8.push_back(e);
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    // Edges from accept to out_valid; returns 100 on timeout.
    task automatic wait_out32(output int lat);
        lat = 1;
        while (!out_valid32 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_out8(output int lat);
        lat = 1;
        while (!out_valid8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release32();
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
    endtask

    task automatic release8();
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        nvec++; if (y32 !== 32'h0) begin nerr++; $display("FAIL reset y: got %h want 0", y32); end
        nvec++; if (out_valid32 !== 1'b0) begin nerr++; $display("FAIL reset out_valid: got %b want 0", out_valid32); end
        nvec++; if (busy32 !== 1'b0) begin nerr++; $display("FAIL reset busy: got %b want 0", busy32); end
        nvec++; if (in_ready32 !== 1'b1) begin nerr++; $display("FAIL reset in_ready: got %b want 1", in_ready32); end
        nvec++; if (in_ready8 !== 1'b1) begin nerr++; $display("FAIL reset in_ready8: got %b want 1", in_ready8); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        vec_t        tbl[12];
        int          lat;
        logic [31:0] exp;
        tbl = '{
            '{5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1},
            '{5'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1},
            '{5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1},
            '{5'd3,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1},
            '{5'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1},
            '{5'd5,  32'h00000001, 32'h0000003F, 32'h80000000, 1},
            '{5'd6,  32'h80000000, 32'h00000024, 32'h08000000, 1},
            '{5'd7,  32'h80000000, 32'h00000024, 32'hF8000000, 1},
            '{5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1},
            '{5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1},
            '{5'd18, 32'h00001234, 32'h00005678, 32'h00000000, 1},
            '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1}
        };
        foreach (tbl[i]) begin
            accept32(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].e);
            wait_out32(lat);
            exp = sb32.pop_front();
            nvec++; if (y32 !== exp) begin nerr++; $display("FAIL basic[%0d] y: got %h want %h", i, y32, exp); end
            nvec++; if (lat != tbl[i].lat) begin nerr++; $display("FAIL basic[%0d] latency: got %0d want %0d", i, lat, tbl[i].lat); end
            nvec++; if (busy32 !== 1'b1) begin nerr++; $display("FAIL basic[%0d] busy in DONE: got %b want 1", i, busy32); end
            release32();
        end
    endtask

    task automatic test_mul();
        vec_t        tbl[7];
        int          lat;
        logic [31:0] exp;
        tbl = '{
            '{5'd11, 32'h80000000, 32'h80000000, 32'h40000000, 33},
            '{5'd10, 32'h80000000, 32'h80000000, 32'h00000000, 33},
            '{5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33},
            '{5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
            '{5'd10, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF1, 33},
            '{5'd11, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 33},
            '{5'd13, 32'h12345678, 32'h00000010, 32'h00000001, 33}
        };
        foreach (tbl[i]) begin
            accept32(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].e);
            wait_out32(lat);
            exp = sb32.pop_front();
            nvec++; if (y32 !== exp) begin nerr++; $display("FAIL mul[%0d] y: got %h want %h", i, y32, exp); end
            nvec++; if (lat != tbl[i].lat) begin nerr++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, tbl[i].lat); end
            release32();
        end
    endtask

    task automatic test_div();
        vec_t        tbl[11];
        int          lat;
        logic [31:0] exp;
        tbl = '{
            '{5'd14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33},
            '{5'd16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33},
            '{5'd15, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1},
            '{5'd17, 32'h00000007, 32'h00000000, 32'h00000007, 1},
            '{5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
            '{5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
            '{5'd15, 32'h00000064, 32'h00000007, 32'h0000000E, 33},
            '{5'd17, 32'h00000064, 32'h00000007, 32'h00000002, 33},
            '{5'd14, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33},
            '{5'd16, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33},
            '{5'd16, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1}
        };
        foreach (tbl[i]) begin
            accept32(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].e);
            wait_out32(lat);
            exp = sb32.pop_front();
            nvec++; if (y32 !== exp) begin nerr++; $display("FAIL div[%0d] y: got %h want %h", i, y32, exp); end
            nvec++; if (lat != tbl[i].lat) begin nerr++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, tbl[i].lat); end
            release32();
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        int          bad;
        logic [31:0] exp;
        accept32(5'd10, 32'd6, 32'd7, 32'd42);
        wait_out32(lat);
        exp = sb32.pop_front();
        nvec++; if (lat != 33) begin nerr++; $display("FAIL bp latency: got %0d want 33", lat); end
        // An offered op must not be taken while a result is held.
        in_valid32 = 1'b1; ctrl32 = 5'd0; a32 = 32'd1; b32 = 32'd1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid32 !== 1'b1 || y32 !== exp || in_ready32 !== 1'b0) bad++;
            @(negedge clk);
        end
        in_valid32 = 1'b0;
        nvec++; if (bad != 0) begin nerr++; $display("FAIL bp hold: %0d unstable cycles, want 0 (y=%h want %h)", bad, y32, exp); end
        nvec++; if (y32 !== exp) begin nerr++; $display("FAIL bp y: got %h want %h", y32, exp); end
        release32();
        nvec++; if (in_ready32 !== 1'b1) begin nerr++; $display("FAIL bp release in_ready: got %b want 1", in_ready32); end
        nvec++; if (out_valid32 !== 1'b0) begin nerr++; $display("FAIL bp release out_valid: got %b want 0", out_valid32); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  c;
        logic [31:0] x, z, e, exp;
        @(negedge clk);
        out_ready32 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x = $urandom; z = $urandom;
            case (i % 3)
                0:       begin c = 5'd0; e = x + z; end
                1:       begin c = 5'd4; e = x ^ z; end
                default: begin c = 5'd9; e = (x < z) ? 32'd1 : 32'd0; end
            endcase
            in_valid32 = 1'b1; ctrl32 = c; a32 = x; b32 = z;
            @(posedge clk);
            sb32.push_back(e);
            @(negedge clk);
            exp = sb32.pop_front();
            nvec++; if (out_valid32 !== 1'b1 || y32 !== exp) begin
                nerr++; $display("FAIL b2b[%0d]: got v=%b y=%h want v=1 y=%h", i, out_valid32, y32, exp);
            end
            a32 = $urandom; b32 = $urandom;
            @(negedge clk);
        end
        in_valid32 = 1'b0; out_ready32 = 1'b0;
    endtask

    task automatic test_flush();
        int          lat;
        int          seen;
        logic [31:0] exp;
        accept32(5'd15, 32'hFFFFFFFF, 32'd3, 32'h55555555);
        seen = 0;
        repeat (11) begin
            if (out_valid32) seen++;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(sb32.pop_back());
        nvec++; if (busy32 !== 1'b0 || in_ready32 !== 1'b1) begin
            nerr++; $display("FAIL flush state: got busy=%b in_ready=%b want 0/1", busy32, in_ready32);
        end
        repeat (40) begin
            if (out_valid32) seen++;
            @(negedge clk);
        end
        nvec++; if (seen != 0) begin nerr++; $display("FAIL flush out_valid: seen %0d cycles want 0", seen); end
        // Accept offered together with flush must be dropped.
        in_valid32 = 1'b1; ctrl32 = 5'd0; a32 = 32'd9; b32 = 32'd9; flush = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0; flush = 1'b0;
        nvec++; if (busy32 !== 1'b0) begin nerr++; $display("FAIL flush accept: got busy=%b want 0", busy32); end
        accept32(5'd0, 32'd3, 32'd4, 32'd7);
        wait_out32(lat);
        exp = sb32.pop_front();
        nvec++; if (y32 !== exp || lat != 1) begin
            nerr++; $display("FAIL flush add: got y=%h lat=%0d want y=%h lat=1", y32, lat, exp);
        end
        release32();
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] exp;
        accept32(5'd13, 32'hDEADBEEF, 32'h12345678, 32'h0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb32.pop_back());
        nvec++; if (y32 !== 32'h0 || out_valid32 !== 1'b0 || busy32 !== 1'b0 || in_ready32 !== 1'b1) begin
            nerr++; $display("FAIL midreset: got y=%h v=%b busy=%b rdy=%b want 0/0/0/1",
                             y32, out_valid32, busy32, in_ready32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        accept32(5'd0, 32'd3, 32'd4, 32'd7);
        wait_out32(lat);
        exp = sb32.pop_front();
        nvec++; if (y32 !== exp || lat != 1) begin
            nerr++; $display("FAIL midreset add: got y=%h lat=%0d want y=%h lat=1", y32, lat, exp);
        end
        release32();
    endtask

    task automatic test_xlen8();
        logic [4:0] cs[6];
        logic [7:0] as[6], bs[6], es[6];
        int         ls[6];
        int         lat;
        logic [7:0] exp;
        cs = '{5'd13, 5'd14, 5'd5,  5'd20, 5'd10, 5'd16};
        as = '{8'hFF, 8'h80, 8'h81, 8'h5A, 8'hF0, 8'h85};
        bs = '{8'hFF, 8'hFF, 8'h0B, 8'hA5, 8'h03, 8'h07};
        es = '{8'hFE, 8'h80, 8'h08, 8'h00, 8'hD0, 8'hFC};
        ls = '{9,     1,     1,     1,     9,     9};
        for (int i = 0; i < 6; i++) begin
            accept8(cs[i], as[i], bs[i], es[i]);
            wait_out8(lat);
            exp = sb8.pop_front();
            nvec++; if (y8 !== exp) begin nerr++; $display("FAIL x8[%0d] y: got %h want %h", i, y8, exp); end
            nvec++; if (lat != ls[i]) begin nerr++; $display("FAIL x8[%0d] latency: got %0d want %0d", i, lat, ls[i]); end
            release8();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_xlen8();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
